// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I-subset core: one shared memory port, FETCH/DECODE/EXEC/MEM/WB control FSM.
// Unsupported encodings, out-of-range registers and misaligned addresses park the core in HALT.
module multi_cycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst_l,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic [31:0] retire_pc,
    output logic        halted
);
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
    logic [31:0] rf_q [NUM_REGS];
    logic [31:0] rf_d [NUM_REGS];

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        is_r, is_i, is_lw, is_sw, is_beq, is_jal, legal;
    logic        rd_ok, rs1_ok, rs2_ok, f3_alu;
    logic [31:0] imm_dec, op2, alu, ea, tgt, pc4, br_nxt;
    logic        req_c, we_c;
    logic [31:0] addr_c, wdata_c;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];

    always_comb begin
        is_r   = (opcode == 7'b0110011);
        is_i   = (opcode == 7'b0010011);
        is_lw  = (opcode == 7'b0000011) && (f3 == 3'b010);
        is_sw  = (opcode == 7'b0100011) && (f3 == 3'b010);
        is_beq = (opcode == 7'b1100011) && (f3 == 3'b000);
        is_jal = (opcode == 7'b1101111);
        rd_ok  = ({27'd0, rd}  < 32'(NUM_REGS));
        rs1_ok = ({27'd0, rs1} < 32'(NUM_REGS));
        rs2_ok = ({27'd0, rs2} < 32'(NUM_REGS));
        f3_alu = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
        // Only register fields the format actually uses are range-checked.
        legal  = (is_r && rd_ok && rs1_ok && rs2_ok &&
                     ((f7 == 7'h00 && f3_alu) || (f7 == 7'h20 && f3 == 3'b000)))
              || (is_i && f3_alu && rd_ok && rs1_ok)
              || (is_lw && rd_ok && rs1_ok)
              || ((is_sw || is_beq) && rs1_ok && rs2_ok)
              || (is_jal && rd_ok);
        if (is_sw)       imm_dec = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        else if (is_beq) imm_dec = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        else if (is_jal) imm_dec = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
        else             imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
    end

    always_comb begin
        op2 = is_r ? b_q : imm_q;
        case (f3)
            3'b111:  alu = a_q & op2;
            3'b110:  alu = a_q | op2;
            3'b010:  alu = {31'd0, $signed(a_q) < $signed(op2)};
            default: alu = (is_r && f7[5]) ? a_q - op2 : a_q + op2;
        endcase
        ea     = a_q + imm_q;
        tgt    = pc_q + imm_q;
        pc4    = pc_q + 32'd4;
        br_nxt = (a_q == b_q) ? tgt : pc4;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        res_d   = res_q;
        rf_d    = rf_q;
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = 32'd0;
        wdata_c = 32'd0;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c  = 1'b1;
                addr_c = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_d = S_HALT;
                end else begin
                    a_d     = rf_q[rs1[RW-1:0]];
                    b_d     = rf_q[rs2[RW-1:0]];
                    imm_d   = imm_dec;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    res_d   = ea;
                    state_d = (ea[1:0] != 2'b00) ? S_HALT : S_MEM;
                end else if (is_beq) begin
                    if (br_nxt[1:0] != 2'b00) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = br_nxt;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (is_jal) begin
                    if (tgt[1:0] != 2'b00) begin
                        state_d = S_HALT;
                    end else begin
                        if (rd != 5'd0) rf_d[rd[RW-1:0]] = pc4;
                        pc_d    = tgt;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    res_d   = alu;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                req_c   = 1'b1;
                addr_c  = res_q;
                we_c    = is_sw;
                wdata_c = is_sw ? b_q : 32'd0;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_d    = pc4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        res_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                if (rd != 5'd0) rf_d[rd[RW-1:0]] = res_q;
                pc_d    = pc4;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // The reset state is FETCH, so the port is gated by rst_l to stay quiet while held in reset.
    assign mem_req   = rst_l & req_c;
    assign mem_we    = rst_l & we_c;
    assign mem_addr  = rst_l ? addr_c : 32'd0;
    assign mem_wdata = rst_l ? wdata_c : 32'd0;
    assign retire_pc = retire ? pc_q : 32'd0;
    assign halted    = (state_q == S_HALT);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            imm_q   <= 32'd0;
            res_q   <= 32'd0;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            res_q   <= res_d;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= (i == 0) ? 32'd0 : rf_d[i];
        end
    end
endmodule

// File: tb/tb_multi_cycle_core.sv
// Directed bench for multi_cycle_core: an instruction-level reference model predicts retire PCs,
// per-instruction cycle counts and stores; a per-cycle monitor compares the DUT port against it.
module tb_multi_cycle_core;
    logic        clk = 1'b0;
    logic        rst32, rst16;
    logic        mem_ready = 1'b1;
    logic        req32, we32, ret32, hlt32, req16, we16, ret16, hlt16;
    logic [31:0] addr32, wd32, rd32, rpc32, addr16, wd16, rd16, rpc16;
    logic [31:0] mem [0:1023];
    int          mode = 0;
    bit          tog = 1'b0;
    bit          sel = 1'b0;
    int          pass = 0, total = 0;

    logic [31:0] exp_pc [$];
    int          exp_cpi [$];
    logic [31:0] st_a [$];
    logic [31:0] st_d [$];

    always #5 clk = ~clk;

    multi_cycle_core #(.RESET_PC(32'h100), .NUM_REGS(32)) dut32 (
        .clk(clk), .rst_l(rst32), .mem_req(req32), .mem_we(we32), .mem_addr(addr32),
        .mem_wdata(wd32), .mem_rdata(rd32), .mem_ready(mem_ready), .retire(ret32),
        .retire_pc(rpc32), .halted(hlt32));

    multi_cycle_core #(.RESET_PC(32'h100), .NUM_REGS(16)) dut16 (
        .clk(clk), .rst_l(rst16), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
        .mem_wdata(wd16), .mem_rdata(rd16), .mem_ready(mem_ready), .retire(ret16),
        .retire_pc(rpc16), .halted(hlt16));

    assign rd32 = mem[addr32[11:2]];
    assign rd16 = mem[addr16[11:2]];

    logic        c_rst, c_req, c_we, c_ret, c_hlt;
    logic [31:0] c_addr, c_wd, c_rpc;
    assign c_rst  = sel ? rst16  : rst32;
    assign c_req  = sel ? req16  : req32;
    assign c_we   = sel ? we16   : we32;
    assign c_ret  = sel ? ret16  : ret32;
    assign c_hlt  = sel ? hlt16  : hlt32;
    assign c_addr = sel ? addr16 : addr32;
    assign c_wd   = sel ? wd16   : wd32;
    assign c_rpc  = sel ? rpc16  : rpc32;

    always @(posedge clk) begin
        if (req32 && mem_ready && we32) mem[addr32[11:2]] = wd32;
        if (req16 && mem_ready && we16) mem[addr16[11:2]] = wd16;
    end

    // mode 0: always ready, 1: alternating, 2: never ready
    always @(posedge clk) begin
        #1;
        case (mode)
            0: mem_ready = 1'b1;
            1: begin mem_ready = tog; tog = ~tog; end
            default: mem_ready = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (ok) pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] a, b, c, d, e;
        a = f7; b = rs2; c = rs1; d = f3; e = rd;
        return {a[6:0], b[4:0], c[4:0], d[2:0], e[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] a, c, d, e, o;
        a = imm; c = rs1; d = f3; e = rd; o = op;
        return {a[11:0], c[4:0], d[2:0], e[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] a, b, c;
        a = imm; b = rs2; c = rs1;
        return {a[11:5], b[4:0], c[4:0], 3'b010, a[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
        logic [31:0] a, b, c;
        a = imm; b = rs2; c = rs1;
        return {a[12], a[10:5], b[4:0], c[4:0], 3'b000, a[4:1], a[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] a, e;
        a = imm; e = rd;
        return {a[20], a[10:1], a[11], a[19:12], e[4:0], 7'h6F};
    endfunction

    // Instruction-set level reference: runs the loaded program and queues what the core must show.
    task automatic iss_run(input int nregs);
        logic [31:0] m [0:1023];
        logic [31:0] x [0:31];
        logic [31:0] pc, ins, a, b, b2, r, ea_l, ea_s, immi, imms, immb, immj, bt;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        int          rd, rs1, rs2;
        bit          ok, use_rd;
        exp_pc.delete(); exp_cpi.delete(); st_a.delete(); st_d.delete();
        for (int i = 0; i < 1024; i++) m[i] = mem[i];
        for (int i = 0; i < 32; i++) x[i] = 0;
        pc = 32'h100;
        for (int s = 0; s < 200; s++) begin
            ins = m[pc[11:2]];
            op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
            rd = int'(ins[11:7]); rs1 = int'(ins[19:15]); rs2 = int'(ins[24:20]);
            immi = {{20{ins[31]}}, ins[31:20]};
            imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            immj = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            a = x[rs1]; b = x[rs2];
            ea_l = a + immi; ea_s = a + imms;
            bt = (a == b) ? pc + immb : pc + 4;
            case (op)
                7'h33: ok = ((f7 == 0 && (f3 == 0 || f3 == 7 || f3 == 6 || f3 == 2)) || (f7 == 7'h20 && f3 == 0))
                            && rd < nregs && rs1 < nregs && rs2 < nregs;
                7'h13: ok = (f3 == 0 || f3 == 7 || f3 == 6 || f3 == 2) && rd < nregs && rs1 < nregs;
                7'h03: ok = f3 == 2 && rd < nregs && rs1 < nregs && ea_l[1:0] == 0;
                7'h23: ok = f3 == 2 && rs1 < nregs && rs2 < nregs && ea_s[1:0] == 0;
                7'h63: ok = f3 == 0 && rs1 < nregs && rs2 < nregs && bt[1:0] == 0;
                7'h6F: ok = rd < nregs && ((pc + immj) & 32'd3) == 0;
                default: ok = 0;
            endcase
            if (!ok) break;
            exp_pc.push_back(pc);
            use_rd = 1;
            r = 0;
            case (op)
                7'h33, 7'h13: begin
                    b2 = (op == 7'h33) ? b : immi;
                    case (f3)
                        3'd7: r = a & b2;
                        3'd6: r = a | b2;
                        3'd2: r = ($signed(a) < $signed(b2)) ? 32'd1 : 32'd0;
                        default: r = (op == 7'h33 && f7 == 7'h20) ? a - b2 : a + b2;
                    endcase
                    exp_cpi.push_back(4); pc = pc + 4;
                end
                7'h03: begin r = m[ea_l[11:2]]; exp_cpi.push_back(5); pc = pc + 4; end
                7'h23: begin
                    m[ea_s[11:2]] = b; st_a.push_back(ea_s); st_d.push_back(b);
                    use_rd = 0; exp_cpi.push_back(4); pc = pc + 4;
                end
                7'h63: begin use_rd = 0; exp_cpi.push_back(3); pc = bt; end
                default: begin r = pc + 4; exp_cpi.push_back(3); pc = pc + immj; end
            endcase
            if (use_rd && rd != 0) x[rd] = r;
        end
    endtask

    // Per-cycle monitor: retire PC/spacing, store contents, and request stability across stalls.
    int          cnt = 0, waits = 0;
    bit          prev_stall = 0;
    logic [31:0] p_addr, p_wd, e1, e2;
    logic        p_we;
    int          ec;
    always @(negedge clk) begin
        if (c_rst) begin
            cnt++;
            if (prev_stall)
                chk("stall_hold", c_req && c_addr == p_addr && c_we == p_we && c_wd == p_wd, c_addr, p_addr);
            if (c_req && !mem_ready) waits++;
            if (c_req && mem_ready && c_we) begin
                if (st_a.size() == 0) chk("store_unexpected", 1'b0, c_addr, 32'd0);
                else begin
                    e1 = st_a.pop_front(); e2 = st_d.pop_front();
                    chk("store_addr", c_addr == e1, c_addr, e1);
                    chk("store_data", c_wd == e2, c_wd, e2);
                end
            end
            if (c_ret) begin
                if (exp_pc.size() == 0) chk("retire_unexpected", 1'b0, c_rpc, 32'd0);
                else begin
                    e1 = exp_pc.pop_front(); ec = exp_cpi.pop_front();
                    chk("retire_pc", c_rpc == e1, c_rpc, e1);
                    chk("retire_cycles", cnt == ec + waits, cnt, ec + waits);
                end
                cnt = 0; waits = 0;
            end
            prev_stall = c_req && !mem_ready;
            p_addr = c_addr; p_we = c_we; p_wd = c_wd;
        end else begin
            cnt = 0; waits = 0; prev_stall = 0;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    endtask
    task automatic put(input int idx, input logic [31:0] w);
        mem[64 + idx] = w;
    endtask

    task automatic run(input int m, input bit s, input string tag);
        int  n;
        bit  quiet;
        sel = s; mode = m;
        iss_run(s ? 16 : 32);
        @(posedge clk); #2;
        if (s) rst16 = 1'b1; else rst32 = 1'b1;
        @(negedge clk);
        chk({tag, "_first_fetch"}, c_req && !c_we && c_addr == 32'h100, c_addr, 32'h100);
        n = 0;
        while (!c_hlt && n < 3000) begin @(negedge clk); n++; end
        chk({tag, "_halted"}, c_hlt, {31'd0, c_hlt}, 32'd1);
        quiet = 1;
        repeat (4) begin @(negedge clk); if (c_req || c_ret || !c_hlt) quiet = 0; end
        chk({tag, "_quiet_after_halt"}, quiet, {31'd0, quiet}, 32'd1);
        chk({tag, "_all_retired"}, exp_pc.size() == 0 && st_a.size() == 0, exp_pc.size(), 32'd0);
        rst32 = 1'b0; rst16 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst32 = 1'b0; rst16 = 1'b0;
        // ALU program
        clear_mem();
        put(0,  enc_i(5, 0, 0, 1, 7'h13));
        put(1,  enc_i(-3, 0, 0, 2, 7'h13));
        put(2,  enc_r(0, 2, 1, 0, 3));
        put(3,  enc_r(0, 1, 2, 2, 4));
        put(4,  enc_r(7'h20, 2, 1, 0, 6));
        put(5,  enc_r(0, 2, 1, 7, 7));
        put(6,  enc_r(0, 2, 1, 6, 8));
        put(7,  enc_i(-4, 2, 2, 9, 7'h13));
        put(8,  enc_i(0, 2, 2, 10, 7'h13));
        put(9,  enc_i(15, 2, 7, 11, 7'h13));
        put(10, enc_i(16, 1, 6, 12, 7'h13));
        put(11, enc_s(32, 3, 0));
        put(12, enc_s(36, 4, 0));
        put(13, enc_s(40, 6, 0));
        put(14, enc_s(44, 7, 0));
        put(15, enc_s(48, 8, 0));
        put(16, enc_s(52, 10, 0));
        put(17, enc_s(56, 11, 0));
        put(18, enc_s(60, 12, 0));
        put(19, enc_s(64, 9, 0));
        repeat (3) @(negedge clk);
        chk("rst_req", req32 == 0, {31'd0, req32}, 0);
        chk("rst_we", we32 == 0, {31'd0, we32}, 0);
        chk("rst_addr", addr32 == 0, addr32, 0);
        chk("rst_wdata", wd32 == 0, wd32, 0);
        chk("rst_retire", ret32 == 0 && rpc32 == 0, rpc32, 0);
        chk("rst_halted", hlt32 == 0, {31'd0, hlt32}, 0);
        run(0, 0, "alu");
        chk("alu_add", mem[8] == 32'd2, mem[8], 32'd2);
        chk("alu_slt", mem[9] == 32'd1, mem[9], 32'd1);
        chk("alu_sub", mem[10] == 32'd8, mem[10], 32'd8);
        chk("alu_and", mem[11] == 32'd5, mem[11], 32'd5);
        chk("alu_or", mem[12] == 32'hFFFF_FFFD, mem[12], 32'hFFFF_FFFD);
        chk("alu_slti", mem[13] == 32'd1 && mem[16] == 32'd0, mem[16], 32'd0);
        chk("alu_andi", mem[14] == 32'hD, mem[14], 32'hD);
        chk("alu_ori", mem[15] == 32'h15, mem[15], 32'h15);

        // store/load with a toggling ready
        clear_mem();
        put(0, enc_i(2, 0, 0, 3, 7'h13));
        put(1, enc_s(8, 3, 0));
        put(2, enc_i(8, 0, 2, 5, 7'h03));
        put(3, enc_s(12, 5, 0));
        run(1, 0, "ldst");
        chk("ldst_sw", mem[2] == 32'd2, mem[2], 32'd2);
        chk("ldst_lw", mem[3] == 32'd2, mem[3], 32'd2);

        // branches and jumps
        clear_mem();
        put(0,  enc_i(1, 0, 0, 2, 7'h13));
        put(1,  enc_b(8, 0, 0));
        put(2,  enc_i(99, 0, 0, 2, 7'h13));
        put(3,  enc_b(8, 0, 2));
        put(4,  enc_j(8, 1));
        put(6,  enc_s(16, 1, 0));
        put(7,  enc_s(24, 2, 0));
        put(8,  enc_j(12, 0));
        put(9,  enc_s(20, 1, 0));
        put(11, enc_j(-8, 1));
        run(0, 0, "br");
        chk("br_jal_link", mem[4] == 32'h114, mem[4], 32'h114);
        chk("br_skip", mem[6] == 32'd1, mem[6], 32'd1);
        chk("br_jal_back", mem[5] == 32'h130, mem[5], 32'h130);

        // misaligned load
        clear_mem();
        put(0, enc_i(3, 0, 0, 1, 7'h13));
        put(1, enc_i(0, 1, 2, 2, 7'h03));
        run(0, 0, "misalign");

        // reset while a fetch waits, then an illegal opcode at RESET_PC
        clear_mem();
        sel = 0; mode = 2;
        @(posedge clk); #2; rst32 = 1'b1;
        repeat (3) @(negedge clk);
        chk("stall_req", req32 && addr32 == 32'h100, addr32, 32'h100);
        @(posedge clk); #2; rst32 = 1'b0; #1;
        chk("reset_drop", !req32 && addr32 == 0, {31'd0, req32}, 0);
        run(0, 0, "refetch");

        // RV32E build rejects x20
        clear_mem();
        put(0, enc_i(7, 0, 0, 1, 7'h13));
        put(1, enc_i(1, 0, 0, 20, 7'h13));
        run(0, 1, "rv32e");

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
